load_store_unit: RTL and testbench

- Multi-cycle data-memory front end for the RISC-V core.
- Produces the ReadData word that feeds the writeback result select.
- Converts core load/store requests (address, store data, funct3) into a valid/ready memory-bus transaction with byte strobes.
- Sign/zero-extends load data and stalls the core until the access completes or faults.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/load_align.sv | 25 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the data-memory front end: funct3 encodings,
// load/store unit state encoding and the request legality check.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // 1 when the request must fault without touching the bus.
    function automatic logic access_error(input logic [2:0] funct3, input logic [1:0] addr);
        logic err;
        err = 1'b0;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            err = 1'b1;
        else if (funct3[1:0] == 2'b01 && addr[0])
            err = 1'b1;
        else if (funct3[1:0] == 2'b10 && addr != 2'b00)
            err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a bus read word and sign- or
// zero-extends it according to the load funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  data = {24'h000000, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  data = {16'h0000, shifted[15:0]};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory front end: turns a held core load/store request into
// one valid/ready bus transaction and stalls the core until done pulses.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] ReadData,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Bus handshake: a transfer happens on a rising edge where mem_valid and
    // mem_ready are both high; the request fields stay stable while mem_valid
    // waits for mem_ready. Read data is accepted on any edge with mem_rvalid
    // high while in REQ (after acceptance) or WAIT, and is ignored otherwise.

    lsu_state_e      state;
    logic [TO_W-1:0] cnt;
    logic [31:0]     load_word;
    logic [3:0]      strb;
    logic            req_err;

    assign req_err   = access_error(req_funct3, req_addr[1:0]);
    assign stall     = req_valid & ~done;
    assign mem_we    = req_we;
    assign mem_addr  = {req_addr[31:2], 2'b00};
    assign mem_wstrb = req_we ? strb : 4'b0000;
    assign dbg_state = state;

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                mem_wdata = {4{req_wdata[7:0]}};
                strb      = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                mem_wdata = {2{req_wdata[15:0]}};
                strb      = 4'b0011 << req_addr[1:0];
            end
            default: begin
                mem_wdata = req_wdata;
                strb      = 4'b1111;
            end
        endcase
    end

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .addr      (req_addr[1:0]),
        .funct3    (req_funct3),
        .data      (load_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            ReadData  <= 32'h0;
            cnt       <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (req_we) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mem_rvalid) begin
                            ReadData <= load_word;
                            state    <= DONE;
                            done     <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Data arriving on the final allowed cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        ReadData <= load_word;
                        state    <= DONE;
                        done     <= 1'b1;
                    end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a short read timeout.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] ReadData;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks;
    int errors;

    // Results captured by run_access.
    int          r_lat;
    logic        r_fault;
    logic        r_saw_valid;
    logic        r_stall_ok;
    logic        r_stable_ok;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;

    load_store_unit #(.TIMEOUT(4), .TO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .ReadData   (ReadData),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds one request until done; memory accepts after rdy_dly valid cycles and
    // returns read data rv_dly cycles after acceptance (rv_dly < 0: never).
    task automatic run_access(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        int ready_c;
        int vcount;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        mem_rdata = rdata; mem_ready = 1'b0; mem_rvalid = 1'b0;
        r_lat = -1; r_fault = 1'b0; r_saw_valid = 1'b0; r_stall_ok = 1'b1; r_stable_ok = 1'b1;
        r_addr = 32'h0; r_wdata = 32'h0; r_wstrb = 4'h0; r_we = 1'b0;
        ready_c = -1; vcount = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (done === 1'b1) begin
                r_lat = c;
                r_fault = fault;
                break;
            end
            if (stall !== 1'b1) r_stall_ok = 1'b0;
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_valid === 1'b1) begin
                if (!r_saw_valid) begin
                    r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_wdata !== r_wdata || mem_wstrb !== r_wstrb) begin
                    r_stable_ok = 1'b0;
                end
                r_saw_valid = 1'b1;
                vcount++;
                if (vcount > rdy_dly) begin
                    mem_ready = 1'b1;
                    ready_c = c;
                end
            end
            if (ready_c >= 0 && rv_dly >= 0 && c == ready_c + rv_dly) mem_rvalid = 1'b1;
        end
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (r_lat < 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_funct3 = 3'b000; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", ReadData); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sw();
        run_access("sw", 1'b1, 32'h104, 32'hDEADBEEF, 3'b010, 32'h0, 0, -1);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
        checks++; if (r_fault !== 1'b0) begin errors++; $display("FAIL sw_fault: got %b want 0", r_fault); end
        checks++; if (r_addr !== 32'h104) begin errors++; $display("FAIL sw_addr: got %h want 00000104", r_addr); end
        checks++; if (r_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b want 1111", r_wstrb); end
        checks++; if (r_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", r_wdata); end
        checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b want 1", r_we); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_one_cycle: got %b want 0", done); end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL sw_readdata_kept: got %h want 0", ReadData); end
    endtask

    task automatic test_sb_sh();
        run_access("sb", 1'b1, 32'h203, 32'h000000A5, 3'b000, 32'h0, 0, -1);
        checks++; if (r_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", r_wstrb); end
        checks++; if (r_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", r_wdata); end
        checks++; if (r_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", r_addr); end
        step();
        run_access("sh", 1'b1, 32'h202, 32'h00001234, 3'b001, 32'h0, 2, -1);
        checks++; if (r_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", r_wstrb); end
        checks++; if (r_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h want 12341234", r_wdata); end
        checks++; if (r_lat !== 4) begin errors++; $display("FAIL sh_latency: got %0d want 4", r_lat); end
        checks++; if (r_stable_ok !== 1'b1) begin errors++; $display("FAIL sh_held_stable: got %b want 1", r_stable_ok); end
        step();
    endtask

    task automatic test_loads();
        run_access("lb", 1'b0, 32'h102, 32'h0, 3'b000, 32'h0080FF00, 0, 3);
        checks++; if (ReadData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", ReadData); end
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL lb_latency: got %0d want 5", r_lat); end
        checks++; if (r_stall_ok !== 1'b1) begin errors++; $display("FAIL lb_stall: got %b want 1", r_stall_ok); end
        checks++; if (r_wstrb !== 4'b0000) begin errors++; $display("FAIL lb_wstrb: got %b want 0000", r_wstrb); end
        checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", r_we); end
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lb_addr: got %h want 00000100", r_addr); end
        step();
        run_access("lhu", 1'b0, 32'h102, 32'h0, 3'b101, 32'h0080FF00, 0, 0);
        checks++; if (ReadData !== 32'h00000080) begin errors++; $display("FAIL lhu_data: got %h want 00000080", ReadData); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lhu_latency: got %0d want 2", r_lat); end
        step();
        run_access("lh", 1'b0, 32'h100, 32'h0, 3'b001, 32'h00008001, 0, 1);
        checks++; if (ReadData !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h want ffff8001", ReadData); end
        step();
        run_access("lbu", 1'b0, 32'h101, 32'h0, 3'b100, 32'h0080FF00, 0, 0);
        checks++; if (ReadData !== 32'h000000FF) begin errors++; $display("FAIL lbu_data: got %h want 000000ff", ReadData); end
        step();
    endtask

    task automatic test_faults();
        run_access("lw_mis", 1'b0, 32'h102, 32'h0, 3'b010, 32'h12345678, 0, 0);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL lw_mis_latency: got %0d want 1", r_lat); end
        checks++; if (r_fault !== 1'b1) begin errors++; $display("FAIL lw_mis_fault: got %b want 1", r_fault); end
        checks++; if (r_saw_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_bus: got %b want 0", r_saw_valid); end
        checks++; if (ReadData !== 32'h000000FF) begin errors++; $display("FAIL lw_mis_readdata: got %h want 000000ff", ReadData); end
        step();
        run_access("lh_mis", 1'b0, 32'h101, 32'h0, 3'b001, 32'h0, 0, 0);
        checks++; if (r_fault !== 1'b1) begin errors++; $display("FAIL lh_mis_fault: got %b want 1", r_fault); end
        step();
        run_access("f3_011", 1'b0, 32'h0, 32'h0, 3'b011, 32'h0, 0, 0);
        checks++; if (r_fault !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL f3_011_fault: got fault %b lat %0d want 1 1", r_fault, r_lat); end
        step();
        run_access("sw_mis", 1'b1, 32'h106, 32'hCAFEF00D, 3'b010, 32'h0, 0, -1);
        checks++; if (r_fault !== 1'b1 || r_saw_valid !== 1'b0) begin errors++; $display("FAIL sw_mis_fault: got fault %b bus %b want 1 0", r_fault, r_saw_valid); end
        step();
    endtask

    task automatic test_timeout(input logic [31:0] exp_rd);
        run_access("lw_to", 1'b0, 32'h300, 32'h0, 3'b010, 32'h55555555, 0, -1);
        checks++; if (r_lat !== 6) begin errors++; $display("FAIL timeout_latency: got %0d want 6", r_lat); end
        checks++; if (r_fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b want 1", r_fault); end
        checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL timeout_readdata: got %h want %h", ReadData, exp_rd); end
        step();
    endtask

    task automatic test_coincide();
        run_access("lw_edge", 1'b0, 32'h300, 32'h0, 3'b010, 32'h11223344, 0, 4);
        checks++; if (r_lat !== 6) begin errors++; $display("FAIL coincide_latency: got %0d want 6", r_lat); end
        checks++; if (r_fault !== 1'b0) begin errors++; $display("FAIL coincide_fault: got %b want 0", r_fault); end
        checks++; if (ReadData !== 32'h11223344) begin errors++; $display("FAIL coincide_data: got %h want 11223344", ReadData); end
        step();
    endtask

    task automatic test_stray_rvalid();
        mem_rdata = 32'hFFFFFFFF;
        mem_rvalid = 1'b1;
        step(); step();
        mem_rvalid = 1'b0;
        checks++; if (ReadData !== 32'h11223344) begin errors++; $display("FAIL stray_rvalid_data: got %h want 11223344", ReadData); end
        checks++; if (done !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL stray_rvalid_state: got done %b state %0d want 0 0", done, dbg_state); end
    endtask

    task automatic test_back_to_back();
        run_access("b2b_first", 1'b1, 32'h400, 32'h01020304, 3'b010, 32'h0, 0, -1);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL b2b_first_latency: got %0d want 2", r_lat); end
        run_access("b2b_second", 1'b1, 32'h404, 32'h05060708, 3'b000, 32'h0, 0, -1);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL b2b_second_latency: got %0d want 3", r_lat); end
        checks++; if (r_wstrb !== 4'b0001) begin errors++; $display("FAIL b2b_second_wstrb: got %b want 0001", r_wstrb); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500; req_funct3 = 3'b010;
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        step(); step(); step();
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL midwait_reached: got state %0d want 2", dbg_state); end
        req_valid = 1'b0; mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL midwait_reset_ctrl: got valid %b done %b fault %b stall %b want 0 0 0 0", mem_valid, done, fault, stall);
        end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL midwait_reset_readdata: got %h want 0", ReadData); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midwait_reset_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sw();
        test_sb_sh();
        test_loads();
        test_faults();
        test_timeout(32'h000000FF);
        test_coincide();
        test_stray_rvalid();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout(32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
